// File: rtl/axis_ramp_generator.sv
// ---------------------------------------------------------------------------
// axis_ramp_generator
//
// AXI4-Stream test-pattern source. A trigger starts a run of framed ramps.
// Each packet begins at a latched start value and advances by a latched step
// on every accepted beat. The last beat of each packet carries tlast. A run
// lasts a fixed number of packets, or runs continuously until a stop request
// is seen; the run then ends at the next packet boundary.
//
// Parameters:
//   AXIS_TDATA_WIDTH - ramp sample width
//   CNTR_WIDTH       - beat / packet counter width
//
// Ports:
//   aclk, areset            - clock, synchronous active-high reset
//   cfg_start, cfg_step     - first sample and per-beat increment
//   cfg_length              - beats per packet (0: trigger ignored)
//   cfg_packets             - packets per run (0: continuous)
//   trigger, stop           - level-sampled run start / end request
//   m_axis_t*               - AXI4-Stream master (tdata/tvalid/tready/tlast)
//   sts_busy                - high while a run is in progress
//   sts_packets             - packets completed in the current or last run
// ---------------------------------------------------------------------------
module axis_ramp_generator #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_start,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_step,
  input  logic [CNTR_WIDTH-1:0]       cfg_length,
  input  logic [CNTR_WIDTH-1:0]       cfg_packets,
  input  logic                        trigger,
  input  logic                        stop,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        sts_busy,
  output logic [CNTR_WIDTH-1:0]       sts_packets
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNTR_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

  state_t                      state_r,     state_nxt;
  logic [AXIS_TDATA_WIDTH-1:0] start_r,     start_nxt;
  logic [AXIS_TDATA_WIDTH-1:0] step_r,      step_nxt;
  logic [CNTR_WIDTH-1:0]       length_r,    length_nxt;
  logic [CNTR_WIDTH-1:0]       packets_r,   packets_nxt;
  logic [CNTR_WIDTH-1:0]       beat_r,      beat_nxt;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_r,     tdata_nxt;
  logic [CNTR_WIDTH-1:0]       pkt_cnt_r,   pkt_cnt_nxt;
  logic                        stop_pend_r, stop_pend_nxt;

  logic                  run_s;
  logic                  last_beat_s;
  logic                  handshake_s;
  logic                  stop_now_s;
  logic [CNTR_WIDTH-1:0] pkt_inc_s;

  // Output decodes straight from registers: valid/busy are the RUN state,
  // tlast compares the beat counter against the latched length.
  assign run_s         = (state_r == RUN);
  assign last_beat_s   = (beat_r == (length_r - CNT_ONE));
  assign handshake_s   = run_s & m_axis_tready;
  // A stop seen on the final handshake counts as already pending.
  assign stop_now_s    = stop_pend_r | stop;
  assign pkt_inc_s     = pkt_cnt_r + CNT_ONE;

  assign m_axis_tvalid = run_s;
  assign m_axis_tlast  = run_s & last_beat_s;
  assign m_axis_tdata  = tdata_r;
  assign sts_busy      = run_s;
  assign sts_packets   = pkt_cnt_r;

  // State and datapath registers, cleared by the synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r     <= IDLE;
      start_r     <= '0;
      step_r      <= '0;
      length_r    <= '0;
      packets_r   <= '0;
      beat_r      <= '0;
      tdata_r     <= '0;
      pkt_cnt_r   <= '0;
      stop_pend_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      start_r     <= start_nxt;
      step_r      <= step_nxt;
      length_r    <= length_nxt;
      packets_r   <= packets_nxt;
      beat_r      <= beat_nxt;
      tdata_r     <= tdata_nxt;
      pkt_cnt_r   <= pkt_cnt_nxt;
      stop_pend_r <= stop_pend_nxt;
    end
  end

  // Next-state and datapath update for IDLE/RUN.
  always_comb begin
    state_nxt     = state_r;
    start_nxt     = start_r;
    step_nxt      = step_r;
    length_nxt    = length_r;
    packets_nxt   = packets_r;
    beat_nxt      = beat_r;
    tdata_nxt     = tdata_r;
    pkt_cnt_nxt   = pkt_cnt_r;
    stop_pend_nxt = stop_pend_r;

    case (state_r)
      IDLE: begin
        // A zero-length packet could never produce tlast, so such a
        // trigger is dropped rather than starting an endless packet.
        if (trigger && (cfg_length != CNT_ZERO)) begin
          start_nxt     = cfg_start;
          step_nxt      = cfg_step;
          length_nxt    = cfg_length;
          packets_nxt   = cfg_packets;
          tdata_nxt     = cfg_start;
          beat_nxt      = CNT_ZERO;
          pkt_cnt_nxt   = CNT_ZERO;
          stop_pend_nxt = 1'b0;
          state_nxt     = RUN;
        end else begin
          stop_pend_nxt = 1'b0;
        end
      end

      RUN: begin
        if (handshake_s) begin
          if (last_beat_s) begin
            beat_nxt    = CNT_ZERO;
            tdata_nxt   = start_r;
            pkt_cnt_nxt = pkt_inc_s;
            if (((packets_r != CNT_ZERO) && (pkt_inc_s == packets_r)) || stop_now_s) begin
              state_nxt     = IDLE;
              stop_pend_nxt = 1'b0;
            end else begin
              stop_pend_nxt = stop_now_s;
            end
          end else begin
            beat_nxt      = beat_r + CNT_ONE;
            tdata_nxt     = tdata_r + step_r;
            stop_pend_nxt = stop_now_s;
          end
        end else begin
          stop_pend_nxt = stop_now_s;
        end
      end

      default: begin
        state_nxt     = IDLE;
        stop_pend_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_ramp_generator.sv
// ---------------------------------------------------------------------------
// tb_axis_ramp_generator
//
// Self-checking bench. Expected beats are generated arithmetically
// (start + k*step, tlast on the final beat of each packet) into a queue and
// compared against every accepted output beat.
// ---------------------------------------------------------------------------
module tb_axis_ramp_generator;

  localparam int DW = 8;
  localparam int CW = 16;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] cfg_start, cfg_step;
  logic [CW-1:0] cfg_length, cfg_packets;
  logic          trigger, stop;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic          sts_busy;
  logic [CW-1:0] sts_packets;

  int    checks = 0;
  int    passed = 0;
  beat_t exp_q[$];

  axis_ramp_generator #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_start     (cfg_start),
    .cfg_step      (cfg_step),
    .cfg_length    (cfg_length),
    .cfg_packets   (cfg_packets),
    .trigger       (trigger),
    .stop          (stop),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .sts_busy      (sts_busy),
    .sts_packets   (sts_packets)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Reference model: packets of len beats, k-th beat = start + k*step.
  task automatic model_run(input logic [DW-1:0] start, input logic [DW-1:0] step,
                           input int len, input int pkts);
    beat_t b;
    for (int p = 0; p < pkts; p++) begin
      for (int k = 0; k < len; k++) begin
        b.d = start + DW'(k * int'(step));
        b.l = (k == len - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic start_run(input logic [DW-1:0] s, input logic [DW-1:0] st,
                           input int len, input int pkts);
    cfg_start   = s;
    cfg_step    = st;
    cfg_length  = CW'(len);
    cfg_packets = CW'(pkts);
    trigger     = 1'b1;
    tick();
    trigger     = 1'b0;
  endtask

  // Consume n beats, checking each one against the model queue.
  task automatic collect(input int n, input bit rnd, input int stop_idx, input int budget);
    int            acc = 0;
    int            cyc = 0;
    bit            stalled = 1'b0;
    bit            stop_sent = 1'b0;
    logic [DW-1:0] pd = '0;
    logic          pl = 1'b0;
    while (acc < n && cyc < budget) begin
      m_axis_tready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      stop = 1'b0;
      if (acc == stop_idx && !stop_sent) begin
        stop = 1'b1;
        stop_sent = 1'b1;
      end
      checks++;
      if (m_axis_tvalid !== 1'b1 || exp_q.size() == 0 ||
          m_axis_tdata !== exp_q[0].d || m_axis_tlast !== exp_q[0].l) begin
        $display("FAIL beat%0d: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                 acc, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
                 (exp_q.size() != 0) ? exp_q[0].d : 8'h00,
                 (exp_q.size() != 0) ? exp_q[0].l : 1'b0);
      end else passed++;
      checks++;
      if (sts_busy !== m_axis_tvalid)
        $display("FAIL busy_eq_valid: busy=%b want %b", sts_busy, m_axis_tvalid);
      else passed++;
      if (stalled) begin
        checks++;
        if (m_axis_tdata !== pd || m_axis_tlast !== pl)
          $display("FAIL stall_stable: got %h/%b want %h/%b", m_axis_tdata, m_axis_tlast, pd, pl);
        else passed++;
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata;
      pl = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        acc++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      tick();
      cyc++;
    end
    m_axis_tready = 1'b0;
    stop = 1'b0;
    checks++;
    if (acc != n) $display("FAIL collect_timeout: got %0d beats, want %0d", acc, n);
    else passed++;
  endtask

  task automatic check_idle(input string name, input int pkts);
    checks++;
    if (m_axis_tvalid !== 1'b0 || sts_busy !== 1'b0 || sts_packets !== CW'(pkts))
      $display("FAIL %s: valid=%b busy=%b pkts=%0d, want 0/0/%0d",
               name, m_axis_tvalid, sts_busy, sts_packets, pkts);
    else passed++;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) tick();
    areset = 1'b0;
    tick();
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0 ||
        sts_busy !== 1'b0 || sts_packets !== '0)
      $display("FAIL reset: valid=%b last=%b data=%h busy=%b pkts=%0d, want all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, sts_busy, sts_packets);
    else passed++;
  endtask

  task automatic test_fixed_run();
    // stop while IDLE (including the trigger edge) must not shorten the run
    stop = 1'b1;
    tick();
    model_run(8'd10, 8'd3, 4, 2);
    start_run(8'd10, 8'd3, 4, 2);
    stop = 1'b0;
    collect(8, 1'b0, -1, 40);
    check_idle("fixed_end", 2);
  endtask

  task automatic test_backpressure();
    model_run(8'd10, 8'd3, 4, 2);
    start_run(8'd10, 8'd3, 4, 2);
    collect(8, 1'b1, -1, 200);
    check_idle("bp_end", 2);
  endtask

  task automatic test_wrap();
    model_run(8'hFE, 8'h01, 4, 1);
    start_run(8'hFE, 8'h01, 4, 1);
    collect(4, 1'b0, -1, 20);
    check_idle("wrap_end", 1);
    model_run(8'h01, 8'hFF, 4, 1);
    start_run(8'h01, 8'hFF, 4, 1);
    collect(4, 1'b1, -1, 100);
    check_idle("neg_end", 1);
  endtask

  task automatic test_continuous_stop();
    // stop raised while beat 2 of packet 3 is presented (global index 11)
    model_run(8'd7, 8'd5, 5, 3);
    start_run(8'd7, 8'd5, 5, 0);
    collect(15, 1'b0, 11, 60);
    check_idle("cont_stop_end", 3);
    tick();
    check_idle("cont_stop_hold", 3);
  endtask

  task automatic test_guards();
    cfg_length = '0;
    cfg_packets = CW'(1);
    trigger = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (m_axis_tvalid !== 1'b0)
        $display("FAIL len0_trigger: valid=%b want 0", m_axis_tvalid);
      else passed++;
    end
    trigger = 1'b0;
    model_run(8'd5, 8'd7, 3, 2);
    start_run(8'd5, 8'd7, 3, 2);
    // trigger and new config during the run must not disturb it
    trigger = 1'b1;
    cfg_start = 8'd99;
    cfg_step = 8'd1;
    cfg_length = CW'(7);
    cfg_packets = CW'(9);
    collect(6, 1'b1, -1, 100);
    trigger = 1'b0;
    check_idle("guard_end", 2);
    tick();
    check_idle("guard_no_restart", 2);
  endtask

  task automatic test_back_to_back();
    model_run(8'd20, 8'd2, 2, 1);
    cfg_start = 8'd20;
    cfg_step = 8'd2;
    cfg_length = CW'(2);
    cfg_packets = CW'(1);
    trigger = 1'b1;
    tick();
    collect(2, 1'b0, -1, 20);
    trigger = 1'b1;
    check_idle("b2b_gap", 1);
    cfg_start = 8'd40;
    model_run(8'd40, 8'd2, 2, 1);
    tick();
    trigger = 1'b0;
    collect(2, 1'b0, -1, 20);
    check_idle("b2b_second", 1);
  endtask

  task automatic test_reset_mid();
    model_run(8'd50, 8'd4, 4, 1);
    start_run(8'd50, 8'd4, 4, 0);
    collect(2, 1'b0, -1, 20);
    exp_q.delete();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || sts_packets !== '0 || m_axis_tlast !== 1'b0)
      $display("FAIL reset_mid: valid=%b data=%h pkts=%0d last=%b, want 0",
               m_axis_tvalid, m_axis_tdata, sts_packets, m_axis_tlast);
    else passed++;
    model_run(8'd50, 8'd4, 4, 1);
    start_run(8'd50, 8'd4, 4, 1);
    collect(4, 1'b0, -1, 20);
    check_idle("reset_mid_restart", 1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      logic [DW-1:0] s, st;
      int len, pk;
      s  = DW'($urandom);
      st = DW'($urandom);
      len = $urandom_range(1, 6);
      pk  = $urandom_range(1, 3);
      model_run(s, st, len, pk);
      start_run(s, st, len, pk);
      collect(len * pk, 1'b1, -1, 400);
      check_idle("random_end", pk);
      tick();
    end
  endtask

  initial begin
    areset = 1'b1;
    cfg_start = '0;
    cfg_step = '0;
    cfg_length = '0;
    cfg_packets = '0;
    trigger = 1'b0;
    stop = 1'b0;
    m_axis_tready = 1'b0;
    test_reset();
    test_fixed_run();
    test_backpressure();
    test_wrap();
    test_continuous_stop();
    test_guards();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axis_ramp_generator.md
# axis_ramp_generator

Parametrised AXI4-Stream test-pattern source, the successor to the free-running stream counter. On a trigger it emits framed ramps: each packet starts at a programmable value, advances by a programmable step per accepted beat, and ends with `tlast` after a programmable number of beats. It can run a fixed number of packets or run continuously. It sits in front of DMA writers, FIFOs and DSP chains as a deterministic data source for bring-up and loopback tests.

## Interface

Parameters:
- `AXIS_TDATA_WIDTH`, 32: ramp sample width in bits.
- `CNTR_WIDTH`, 16: width of the beat and packet counters.

Ports:
- `aclk`  in  1  clock; all logic on the rising edge.
- `areset`  in  1  reset, synchronous and active-high.
- `cfg_start`  in  AXIS_TDATA_WIDTH  first sample of every packet.
- `cfg_step`  in  AXIS_TDATA_WIDTH  increment per beat (two's-complement wrap).
- `cfg_length`  in  CNTR_WIDTH  beats per packet; 0 means the trigger is ignored.
- `cfg_packets`  in  CNTR_WIDTH  packets per run; 0 means continuous.
- `trigger`  in  1  level-sampled start request.
- `stop`  in  1  level-sampled request to end the run at the next packet boundary.
- `m_axis_tdata`  out  AXIS_TDATA_WIDTH  ramp sample.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  sink ready.
- `m_axis_tlast`  out  1  last beat of a packet.
- `sts_busy`  out  1  high while in RUN.
- `sts_packets`  out  CNTR_WIDTH  packets completed in the current or last run.

## Operation

- States: IDLE and RUN. Reset enters IDLE.
- Reset values:
  - `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`.
  - `sts_busy=0`, `sts_packets=0`.
  - All internal counters and latched config are 0.
- IDLE:
  - `m_axis_tvalid=0`.
  - When `trigger=1` and `cfg_length!=0`, latch `cfg_start`, `cfg_step`, `cfg_length` and `cfg_packets`.
  - On the same edge, load `tdata=cfg_start`, clear the beat counter and `sts_packets`, and go to RUN.
- RUN:
  - `m_axis_tvalid=1`.
  - `m_axis_tlast` = (beat counter == latched length−1), decoded from registers only.
  - Handshake (`tvalid & tready`), non-last beat: `tdata += step` (mod 2^AXIS_TDATA_WIDTH), beat counter +1.
  - Handshake on the last beat:
    - Beat counter returns to 0, `tdata` returns to latched start, `sts_packets` +1.
    - If latched packets !=0 and the new `sts_packets` equals it, go to IDLE.
    - Else, if the stop request is pending, go to IDLE.
    - Otherwise stay in RUN.
- Stop request:
  - `stop` sampled high in RUN sets an internal pending flag; the flag is cleared on entering IDLE.
  - The current packet always completes; a packet is never truncated.
  - `stop` in IDLE has no effect. `stop` on the same cycle as the final handshake ends the run there.
- `trigger` in RUN is ignored. Changes to `cfg_*` during RUN have no effect until the next trigger.
- `sts_packets` holds its final value in IDLE. In continuous mode it wraps modulo 2^CNTR_WIDTH.
- `cfg_length=1`: every beat carries `tlast` and every beat equals `cfg_start`.

## Timing

- Trigger latency: `trigger` sampled high at edge n gives `tvalid=1` with `tdata=cfg_start` after edge n.
- Throughput: one beat per cycle while `tready=1`. No bubbles at packet boundaries within a run.
- AXIS rules:
  - While `tvalid=1` and `tready=0`, `tdata` and `tlast` hold stable.
  - `tvalid` never drops without a handshake, except on reset.
- End of run: `tvalid` falls on the edge that accepts the final `tlast` beat.
- Earliest restart: `trigger` held high during the final beat is sampled in IDLE the next cycle, leaving a one-cycle gap.
- `sts_busy` equals `m_axis_tvalid`.
- Reset mid-packet: the next cycle has `tvalid=0`, with counters and status cleared; no partial-packet completion.

## Test plan

- Fixed run: start=10, step=3, length=4, packets=2, tready=1, one-cycle trigger.
  - Expect 10,13,16,19(last),10,13,16,19(last).
  - Then tvalid=0, sts_packets=2, sts_busy=0.
- Backpressure: same config, tready toggled pseudo-randomly.
  - Identical beat sequence; tdata and tlast stable while stalled; no dropped or duplicated beats.
- Wrap and negative step: width 8, start=0xFE, step=1, length=4.
  - Expect 0xFE,0xFF,0x00,0x01.
  - Step=0xFF from start=0x01 gives 0x01,0x00,0xFF,0xFE.
- Continuous with stop: packets=0, length=5; assert stop for one cycle during beat 2 of packet 3.
  - Packet 3 completes all 5 beats, then IDLE with sts_packets=3.
- Guards:
  - cfg_length=0 plus trigger: tvalid stays 0.
  - trigger during RUN: no restart.
  - cfg change mid-run: output is unchanged.
- Reset mid-packet: assert areset after beat 2 of 4.
  - Next cycle tvalid=0, tdata=0, sts_packets=0.
  - A new trigger restarts from cfg_start.
